spike_logger: RTL and testbench
===============================

SPIKE_LOGGER -- requirements
Module: spike_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TS_W, default 8, timestamp width in bits.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ena  in  1  design enable; low freezes the timestamp and ignores spike_in.
REQ-006 SHALL have port spike_in  in  1  neuron fire output (uo_out[0] of the neuron stage).
REQ-007 SHALL have port clear  in  1  one-cycle pulse; clears the overflow flag.
REQ-008 SHALL have port rd_ready  in  1  consumer ready.
REQ-009 SHALL have port rd_valid  out  1  FIFO non-empty.
REQ-010 SHALL have port rd_data  out  TS_W  timestamp of the oldest logged spike.
REQ-011 SHALL have port count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 SHALL have port overflow  out  1  sticky; an event was dropped.

Function
REQ-013 SHALL keep a free-running TS_W-bit counter ts: +1 per cycle while ena=1; 255->0 wrap at TS_W=8; hold while ena=0.
REQ-014 SHALL register spike_in into spike_q while ena=1; spike_q holds while ena=0.
REQ-015 SHALL detect an event only on a rising edge: ena=1, spike_in=1, spike_q=0; a held-high spike_in logs once.
REQ-016 SHALL write the current ts value (pre-increment) into the FIFO on the event cycle.
REQ-017 SHALL present FIFO head combinationally: rd_valid=(count!=0), rd_data=oldest entry; rd_data don't-care while rd_valid=0.
REQ-018 SHALL pop on rd_valid & rd_ready; rd_ready while empty has no effect.
REQ-019 SHALL have latency exactly 1: an event in cycle N gives rd_valid=1 in cycle N+1 with that timestamp. No same-cycle bypass when empty.
REQ-020 SHALL accept a write while full only if a pop occurs in the same cycle; count stays DEPTH.
REQ-021 SHALL otherwise drop an event while full (FIFO contents unchanged) and set overflow in the next cycle.
REQ-022 SHALL apply simultaneous push and pop with count in 1..DEPTH-1 as count unchanged, order preserved.
REQ-023 SHALL clear overflow on clear=1; if a drop occurs in the same cycle, set wins.
REQ-024 SHALL wrap read/write pointers modulo DEPTH with no gap or duplication of entries.

Reset
REQ-025 SHALL on rst=1 set ts=0, spike_q=0, pointers=0, count=0, rd_valid=0, overflow=0; rd_data don't-care.
REQ-026 SHALL let rst override every other input in the same cycle, including a mid-stream pop or push; FIFO contents are discarded.

Configuration
REQ-027 SHALL, when SPIKE_LOG_DROP_CNT_EN is defined, add output drop_cnt (8 bits).
REQ-028 SHALL increment drop_cnt once per dropped event, saturate at 255, and clear on rst or clear; on a drop in the same cycle as clear, drop_cnt=1.
REQ-029 SHALL, when SPIKE_LOG_DROP_CNT_EN is undefined, omit the drop_cnt port and its logic; all other behaviour is identical.

Structure
REQ-030 SHALL take TS_W and DEPTH defaults and the timestamp typedef ts_t from shared package neuron_pkg.
REQ-031 SHALL implement storage in one sub-module spike_fifo (synchronous FWFT FIFO, push/pop/full/empty/count).
REQ-032 SHALL keep edge detection, the timestamp counter, overflow and drop_cnt in spike_logger.

Verification
REQ-033 SHALL cover: reset, then spike_in 0->1 at ts=5 -> next cycle rd_valid=1, rd_data=5, count=1.
REQ-034 SHALL cover: spike_in held high for 10 cycles from ts=3 -> exactly one entry, rd_data=3.
REQ-035 SHALL cover: 9 edges with rd_ready=0 (DEPTH=8) -> count=8, overflow=1, drop_cnt=1 if enabled; 8 pops return the first 8 timestamps in order.
REQ-036 SHALL cover: FIFO full, edge and pop in the same cycle -> count stays 8, overflow stays 0, new timestamp is last out.
REQ-037 SHALL cover: ena=0 for 4 cycles around an edge -> no entry, ts unchanged; ts advancing past 255 wraps to 0 and logs 0 correctly.
REQ-038 SHALL cover: rst=1 with count=5 and rd_ready=1 -> next cycle count=0, rd_valid=0, overflow=0.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared neuron-pipeline definitions: default spike-logger geometry and the timestamp type.
package neuron_pkg;

   localparam int unsigned TS_W_DEF  = 8;
   localparam int unsigned DEPTH_DEF = 8;

   typedef logic [TS_W_DEF-1:0] ts_t;

endpackage : neuron_pkg

// File: rtl/spike_fifo.sv
// Synchronous first-word-fall-through FIFO holding spike timestamps; a push while full
// is accepted only when a pop frees the slot in the same cycle.
module spike_fifo
   import neuron_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned W     = TS_W_DEF,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [W-1:0]  data_i,
   output logic [W-1:0]  data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push_c, do_pop_c;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rptr_q];
   assign count_o = cnt_q;

   assign do_pop_c  = pop_i & ~empty_o;
   assign do_push_c = push_i & (~full_o | do_pop_c);

   // Power-of-two depth lets the pointers wrap naturally.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push_c) wptr_d = wptr_q + AW'(1);
      if (do_pop_c)  rptr_d = rptr_q + AW'(1);
      case ({do_push_c, do_pop_c})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push_c) mem_q[wptr_q] <= data_i;
   end

endmodule : spike_fifo

// File: rtl/spike_logger.sv
// Logs the timestamp of each rising edge of the neuron fire output into a small FIFO.
// Defining SPIKE_LOG_DROP_CNT_EN adds a saturating 8-bit dropped-event counter (drop_cnt).
module spike_logger
   import neuron_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned TS_W  = TS_W_DEF,
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic            spike_in,
   input  logic            clear,
   input  logic            rd_ready,
   output logic            rd_valid,
   output logic [TS_W-1:0] rd_data,
   output logic [CW-1:0]   count,
   output logic            overflow
`ifdef SPIKE_LOG_DROP_CNT_EN
   ,
   output logic [7:0]      drop_cnt
`endif
);

   logic [TS_W-1:0] ts_q, ts_d;
   logic            spike_q, spike_d;
   logic            overflow_q, overflow_d;
   logic            event_c, pop_c, drop_c;
   logic            full, empty;

   assign event_c  = ena & spike_in & ~spike_q;
   assign pop_c    = ~empty & rd_ready;
   assign drop_c   = event_c & full & ~pop_c;
   assign rd_valid = ~empty;
   assign overflow = overflow_q;

   spike_fifo #(
      .DEPTH (DEPTH),
      .W     (TS_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (event_c),
      .pop_i   (rd_ready),
      .data_i  (ts_q),
      .data_o  (rd_data),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count)
   );

   // A drop in the same cycle as clear leaves overflow set.
   always_comb begin
      ts_d       = ts_q;
      spike_d    = spike_q;
      overflow_d = overflow_q;
      if (ena) begin
         ts_d    = ts_q + TS_W'(1);
         spike_d = spike_in;
      end
      if (drop_c)     overflow_d = 1'b1;
      else if (clear) overflow_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q       <= '0;
         spike_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         ts_q       <= ts_d;
         spike_q    <= spike_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef SPIKE_LOG_DROP_CNT_EN
   logic [7:0] drop_q, drop_d;

   assign drop_cnt = drop_q;

   always_comb begin
      drop_d = drop_q;
      if (clear)                      drop_d = drop_c ? 8'd1 : 8'd0;
      else if (drop_c && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) drop_q <= '0;
      else     drop_q <= drop_d;
   end
`endif

endmodule : spike_logger

// File: tb/tb_spike_logger.sv
// Randomised + directed bench for spike_logger against a queue-based reference model.
module tb_spike_logger;
   import neuron_pkg::*;

   logic       clk = 1'b0;
   logic       rst, ena, spike_in, clear, rd_ready;
   logic       rd_valid, overflow;
   ts_t        rd_data;
   logic [3:0] count;
`ifdef SPIKE_LOG_DROP_CNT_EN
   logic [7:0] drop_cnt;
`endif

   int tests  = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   // Reference model state
   int m_q[$];
   int m_ts  = 0;
   bit m_sp  = 1'b0;
   bit m_ovf = 1'b0;
   int m_dc  = 0;

   always #5 clk = ~clk;

   spike_logger #(.DEPTH(8), .TS_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .spike_in (spike_in),
      .clear    (clear),
      .rd_ready (rd_ready),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .count    (count),
      .overflow (overflow)
`ifdef SPIKE_LOG_DROP_CNT_EN
      ,
      .drop_cnt (drop_cnt)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: apply one clock edge of the specified behaviour to the queue.
   always @(posedge clk) begin
      bit pop, ev, drop;
      if (rst) begin
         m_q.delete();
         m_ts = 0; m_sp = 1'b0; m_ovf = 1'b0; m_dc = 0;
      end else begin
         pop  = rd_ready && (m_q.size() != 0);
         ev   = ena && spike_in && !m_sp;
         drop = ev && (m_q.size() == 8) && !pop;
         if (pop) void'(m_q.pop_front());
         if (ev && !drop) m_q.push_back(m_ts);
         if (drop)       m_ovf = 1'b1;
         else if (clear) m_ovf = 1'b0;
         if (clear)     m_dc = drop ? 1 : 0;
         else if (drop) m_dc = (m_dc < 255) ? m_dc + 1 : 255;
         if (ena) begin
            m_ts = (m_ts + 1) % 256;
            m_sp = spike_in;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("m_rd_valid", int'(rd_valid), int'(m_q.size() != 0));
         chk("m_count", int'(count), m_q.size());
         chk("m_overflow", int'(overflow), int'(m_ovf));
         if (m_q.size() != 0) chk("m_rd_data", int'(rd_data), m_q[0]);
`ifdef SPIKE_LOG_DROP_CNT_EN
         chk("m_drop_cnt", int'(drop_cnt), m_dc);
`endif
      end
   end

   task automatic drive(input bit r, input bit e, input bit s, input bit c, input bit k);
      rst = r; ena = e; spike_in = s; clear = c; rd_ready = k;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; spike_in = 1'b0; clear = 1'b0; rd_ready = 1'b0;
      #1;
      drive(1, 0, 0, 0, 0);
      cmp_on = 1'b1;
      drive(1, 0, 0, 0, 0);
      chk("rst_count", int'(count), 0);
      chk("rst_valid", int'(rd_valid), 0);
      chk("rst_ovf", int'(overflow), 0);

      // First logged edge at ts=5
      repeat (5) drive(0, 1, 0, 0, 0);
      drive(0, 1, 1, 0, 0);
      chk("ts5_valid", int'(rd_valid), 1);
      chk("ts5_data", int'(rd_data), 5);
      chk("ts5_count", int'(count), 1);

      // Held-high spike logs once
      drive(1, 0, 0, 0, 0);
      repeat (3) drive(0, 1, 0, 0, 0);
      repeat (10) drive(0, 1, 1, 0, 0);
      chk("hold_count", int'(count), 1);
      chk("hold_data", int'(rd_data), 3);

      // Nine edges into an 8-deep FIFO, then a drop coinciding with clear
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         drive(0, 1, 1, 0, 0);
         drive(0, 1, 0, 0, 0);
      end
      chk("ovf_count", int'(count), 8);
      chk("ovf_flag", int'(overflow), 1);
`ifdef SPIKE_LOG_DROP_CNT_EN
      chk("ovf_dcnt", int'(drop_cnt), 1);
`endif
      drive(0, 1, 1, 1, 0);
      chk("clrdrop_flag", int'(overflow), 1);
`ifdef SPIKE_LOG_DROP_CNT_EN
      chk("clrdrop_dcnt", int'(drop_cnt), 1);
`endif
      for (int i = 0; i < 8; i++) begin
         chk("ovf_order", int'(rd_data), 2 * i);
         drive(0, 1, 0, 0, 1);
      end
      chk("drained_count", int'(count), 0);
      chk("drained_ovf", int'(overflow), 1);
      drive(0, 1, 0, 1, 0);
      chk("clear_ovf", int'(overflow), 0);

      // Full FIFO with simultaneous edge and pop
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 1, 0, 0);
         drive(0, 1, 0, 0, 0);
      end
      drive(0, 1, 1, 0, 1);
      chk("fullpp_count", int'(count), 8);
      chk("fullpp_ovf", int'(overflow), 0);
      for (int i = 0; i < 8; i++) begin
         chk("fullpp_order", int'(rd_data), 2 * (i + 1));
         drive(0, 1, 0, 0, 1);
      end

      // Enable low around an edge, then timestamp wrap
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 0, 0, 0);
      chk("ena0_count", int'(count), 0);
      drive(0, 1, 0, 0, 0);
      drive(0, 1, 1, 0, 0);
      chk("ena0_ts", int'(rd_data), 1);
      drive(0, 1, 0, 0, 1);
      repeat (253) drive(0, 1, 0, 0, 0);
      drive(0, 1, 1, 0, 0);
      chk("wrap_count", int'(count), 1);
      chk("wrap_data", int'(rd_data), 0);

      // Reset mid-stream with a pop pending
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 1, 0, 0);
         drive(0, 1, 0, 0, 0);
      end
      chk("pre_rst_count", int'(count), 5);
      drive(1, 1, 1, 0, 1);
      chk("midrst_count", int'(count), 0);
      chk("midrst_valid", int'(rd_valid), 0);
      chk("midrst_ovf", int'(overflow), 0);

      // Random traffic, biased so the FIFO both fills and drains
      for (int i = 0; i < 4000; i++) begin
         bit r, e, s, c, k;
         r = ($urandom_range(0, 299) == 0);
         e = ($urandom_range(0, 9) != 0);
         s = $urandom_range(0, 1) == 1;
         c = ($urandom_range(0, 19) == 0);
         k = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 20 : 70));
         drive(r, e, s, c, k);
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule : tb_spike_logger
